// File: rtl/imem_byte_loader.sv
// imem_byte_loader: packs a valid/ready byte stream into big-endian 32-bit
// words and writes them to the instruction memory at byte addresses 0, 4, 8...
// The first byte of each group of four lands in bits [31:24].
//
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to get a running XOR of
// every accepted byte on `checksum`. Without it, `checksum` is tied to 8'h00.
`default_nettype none

module imem_byte_loader #(
    parameter int MAX_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [6:0]  len_words,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic [7:0]  checksum
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [6:0] MAX_LEN = 7'(MAX_WORDS);

    state_t      state;
    logic [6:0]  len_q;      // captured (clamped) load length in words
    logic [6:0]  word_cnt;   // words written so far in this load
    logic [1:0]  byte_cnt;   // bytes of the current word already accepted
    logic [31:0] asm_word;   // word under assembly, big-endian

    logic        start_accept;
    logic        handshake;
    logic [6:0]  len_clamped;
    logic [6:0]  word_cnt_next;

    // Start is only honoured when no load is in flight.
    assign start_accept  = start && ((state == IDLE) || (state == DONE));
    // The loader only accepts bytes in LOAD; byte_ready is exactly that.
    assign handshake     = byte_valid && (state == LOAD);
    assign len_clamped   = (len_words > MAX_LEN) ? MAX_LEN : len_words;
    assign word_cnt_next = word_cnt + 7'd1;

    // Loader FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            len_q      <= 7'd0;
            word_cnt   <= 7'd0;
            byte_cnt   <= 2'd0;
            asm_word   <= 32'h0;
            byte_ready <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 8'h00;
            mem_wdata  <= 32'h0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    mem_we <= 1'b0;
                    if (start_accept) begin
                        len_q    <= len_clamped;
                        word_cnt <= 7'd0;
                        byte_cnt <= 2'd0;
                        done     <= 1'b0;
                        if (len_clamped == 7'd0) begin
                            // Empty load: park in DONE; done comes back next cycle.
                            state      <= DONE;
                            busy       <= 1'b0;
                            byte_ready <= 1'b0;
                        end else begin
                            state      <= LOAD;
                            busy       <= 1'b1;
                            byte_ready <= 1'b1;
                        end
                    end else if (state == DONE) begin
                        done <= 1'b1;
                    end
                end

                LOAD: begin
                    if (handshake) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0:    asm_word[31:24] <= byte_in;
                            2'd1:    asm_word[23:16] <= byte_in;
                            2'd2:    asm_word[15:8]  <= byte_in;
                            default: asm_word[7:0]   <= byte_in;
                        endcase
                        if (byte_cnt == 2'd3) begin
                            // Fourth byte goes straight into the write data so
                            // the strobe can be issued next cycle.
                            state      <= WRITE;
                            byte_ready <= 1'b0;
                            mem_we     <= 1'b1;
                            mem_addr   <= {word_cnt[5:0], 2'b00};
                            mem_wdata  <= {asm_word[31:8], byte_in};
                        end
                    end
                end

                WRITE: begin
                    mem_we   <= 1'b0;
                    word_cnt <= word_cnt_next;
                    if (word_cnt_next == len_q) begin
                        state      <= DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        byte_ready <= 1'b0;
                    end else begin
                        state      <= LOAD;
                        byte_ready <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] checksum_q;

    // Running XOR of accepted bytes; cleared by an accepted start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            checksum_q <= 8'h00;
        end else if (start_accept) begin
            checksum_q <= 8'h00;
        end else if (handshake) begin
            checksum_q <= checksum_q ^ byte_in;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = 8'h00;
`endif

endmodule

`default_nettype wire

// File: tb/tb_imem_byte_loader.sv
// Directed self-checking bench for imem_byte_loader.
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
`timescale 1ns/1ps

module tb_imem_byte_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [6:0]  len_words;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic [7:0]  checksum;

    int checks = 0;
    int errors = 0;

    logic [7:0]  wr_addr[$];
    logic [31:0] wr_data[$];

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CS_ON = 1'b1;
`else
    localparam bit CS_ON = 1'b0;
`endif

    imem_byte_loader #(.MAX_WORDS(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .len_words  (len_words),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    // Memory-side view: a write commits on the edge that ends the mem_we cycle.
    always @(posedge clk) begin
        if (mem_we === 1'b1) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic do_start(input logic [6:0] len);
        start     = 1'b1;
        len_words = len;
        tick();
        start     = 1'b0;
    endtask

    // Offer one byte after `stall` idle cycles, holding it until accepted.
    task automatic send_byte(input logic [7:0] b, input int stall);
        int guard;
        byte_valid = 1'b0;
        for (int s = 0; s < stall; s++) tick();
        byte_valid = 1'b1;
        byte_in    = b;
        guard      = 0;
        while (byte_ready !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        if (guard >= 50) check("ready_timeout", {31'd0, byte_ready}, 32'd1);
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int n;
        n = 0;
        while (done !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
        check("done_wait", {31'd0, done}, 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"},  {31'd0, byte_ready}, 32'd0);
        check({tag, "_we"},     {31'd0, mem_we},     32'd0);
        check({tag, "_addr"},   {24'd0, mem_addr},   32'd0);
        check({tag, "_wdata"},  mem_wdata,           32'd0);
        check({tag, "_busy"},   {31'd0, busy},       32'd0);
        check({tag, "_done"},   {31'd0, done},       32'd0);
        check({tag, "_cksum"},  {24'd0, checksum},   32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        len_words  = 7'd0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        tick();
        tick();
        check_reset_values("rst");
        reset = 1'b0;
        tick();

        // One-word load, bytes on consecutive cycles.
        clear_log();
        do_start(7'd1);
        check("w1_busy",  {31'd0, busy},       32'd1);
        check("w1_ready", {31'd0, byte_ready}, 32'd1);
        send_byte(8'hE3, 0);
        send_byte(8'hA0, 0);
        send_byte(8'h10, 0);
        send_byte(8'h05, 0);
        check("w1_we",    {31'd0, mem_we},     32'd1);
        check("w1_addr",  {24'd0, mem_addr},   32'h00);
        check("w1_wdata", mem_wdata,           32'hE3A01005);
        check("w1_rdy_w", {31'd0, byte_ready}, 32'd0);
        tick();
        check("w1_done",  {31'd0, done},       32'd1);
        check("w1_nbusy", {31'd0, busy},       32'd0);
        check("w1_nrdy",  {31'd0, byte_ready}, 32'd0);
        check("w1_nwe",   {31'd0, mem_we},     32'd0);
        check("w1_cksum", {24'd0, checksum},   CS_ON ? 32'h56 : 32'h00);
        tick();
        check("w1_nwr",   wr_addr.size(),      32'd1);
        if (wr_addr.size() == 1) check("w1_log", wr_data[0], 32'hE3A01005);

        // Four words with a fixed stall pattern on byte_valid.
        clear_log();
        do_start(7'd4);
        check("w4_ndone", {31'd0, done}, 32'd0);
        for (int i = 0; i < 16; i++) send_byte(8'(i), (i * 7) % 3);
        wait_done(40);
        check("w4_nwr", wr_addr.size(), 32'd4);
        if (wr_addr.size() == 4) begin
            check("w4_a0", {24'd0, wr_addr[0]}, 32'h00);
            check("w4_d0", wr_data[0],          32'h00010203);
            check("w4_a1", {24'd0, wr_addr[1]}, 32'h04);
            check("w4_d1", wr_data[1],          32'h04050607);
            check("w4_a2", {24'd0, wr_addr[2]}, 32'h08);
            check("w4_d2", wr_data[2],          32'h08090A0B);
            check("w4_a3", {24'd0, wr_addr[3]}, 32'h0C);
            check("w4_d3", wr_data[3],          32'h0C0D0E0F);
        end
        check("w4_cksum", {24'd0, checksum}, 32'h00);

        // Zero-length load: no write, done returns without a busy phase.
        clear_log();
        do_start(7'd0);
        check("z_busy",  {31'd0, busy},       32'd0);
        check("z_we",    {31'd0, mem_we},     32'd0);
        check("z_rdy",   {31'd0, byte_ready}, 32'd0);
        tick();
        check("z_done",  {31'd0, done},       32'd1);
        tick();
        check("z_nwr",   wr_addr.size(),      32'd0);

        // Start during LOAD is ignored; original length of 2 words holds.
        clear_log();
        do_start(7'd2);
        send_byte(8'hAA, 0);
        start     = 1'b1;
        len_words = 7'd1;
        tick();
        start     = 1'b0;
        check("ign_busy", {31'd0, busy}, 32'd1);
        send_byte(8'hBB, 0);
        send_byte(8'hCC, 0);
        send_byte(8'hDD, 0);
        tick();
        check("ign_mid",  {31'd0, done}, 32'd0);
        for (int i = 0; i < 4; i++) send_byte(8'(8'h11 * (i + 1)), 0);
        wait_done(20);
        check("ign_nwr", wr_addr.size(), 32'd2);
        if (wr_addr.size() == 2) begin
            check("ign_d0", wr_data[0],          32'hAABBCCDD);
            check("ign_a1", {24'd0, wr_addr[1]}, 32'h04);
            check("ign_d1", wr_data[1],          32'h11223344);
        end

        // Full 64-word load.
        clear_log();
        do_start(7'd64);
        for (int i = 0; i < 256; i++) send_byte(8'(i), 0);
        wait_done(20);
        check("full_nwr", wr_addr.size(), 32'd64);
        if (wr_addr.size() == 64) begin
            check("full_alast", {24'd0, wr_addr[63]}, 32'hFC);
            check("full_dlast", wr_data[63],          32'hFCFDFEFF);
            check("full_a20",   {24'd0, wr_addr[20]}, 32'h50);
        end

        // Length above 64 clamps to 64 words.
        clear_log();
        do_start(7'd100);
        for (int i = 0; i < 256; i++) send_byte(8'(255 - i), 0);
        wait_done(20);
        byte_valid = 1'b1;
        byte_in    = 8'h5A;
        tick();
        tick();
        byte_valid = 1'b0;
        check("clamp_nwr",  wr_addr.size(),      32'd64);
        check("clamp_rdy",  {31'd0, byte_ready}, 32'd0);
        if (wr_addr.size() == 64)
            check("clamp_alast", {24'd0, wr_addr[63]}, 32'hFC);

        // Reset after 2 of 4 bytes: immediate clear, partial word dropped.
        clear_log();
        do_start(7'd1);
        send_byte(8'h9A, 0);
        send_byte(8'hBC, 0);
        reset = 1'b1;
        #1;
        check_reset_values("mid");
        tick();
        reset = 1'b0;
        tick();
        tick();
        check("mid_nwr", wr_addr.size(), 32'd0);

        // Fresh one-word load after reset, also exercising the checksum.
        do_start(7'd1);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        send_byte(8'h56, 0);
        send_byte(8'h78, 0);
        check("post_addr",  {24'd0, mem_addr}, 32'h00);
        check("post_wdata", mem_wdata,         32'h12345678);
        wait_done(5);
        check("post_cksum", {24'd0, checksum}, CS_ON ? 32'h08 : 32'h00);
        tick();
        check("post_nwr", wr_addr.size(), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_byte_loader.md
# imem_byte_loader

Byte-stream loader for the byte-addressed instruction memory. It accepts a stream of 8-bit bytes over a valid/ready handshake and packs each four consecutive bytes big-endian into a 32-bit word. Each word is written through a word-wide write port at byte addresses 0, 4, 8, and so on, so that a later 32-bit fetch at address A returns {Mem[A], Mem[A+1], Mem[A+2], Mem[A+3]}. It replaces file-based preloading and is the writer side of the instruction memory.

## Interface
- `MAX_WORDS`, 64: largest load length in words. The 256-byte memory holds 64 words.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `start` input 1: begin a load. Sampled only in IDLE or DONE.
- `len_words` input 7: number of words to load, 0..64. Captured on start; values above 64 are clamped to 64.
- `byte_in` input 8: stream byte.
- `byte_valid` input 1: `byte_in` is valid.
- `byte_ready` output 1: the loader accepts a byte this cycle.
- `mem_we` output 1: one-cycle word write strobe.
- `mem_addr` output 8: byte address of the word being written; always a multiple of 4.
- `mem_wdata` output 32: packed word; the first byte received is in bits [31:24].
- `busy` output 1: a load is in progress (LOAD or WRITE state).
- `done` output 1: level; the last load has completed. Stays high until the next accepted start.
- `checksum` output 8: see Configuration.

## Operation
- States: IDLE, LOAD, WRITE, DONE.
- IDLE/DONE + start=1:
  - Captures `len_words`.
  - Clears the word counter, the byte counter (2-bit) and `done`.
  - Goes to LOAD, or straight to DONE if `len_words`=0. In that case `done` is re-asserted the next cycle and no write occurs.
- LOAD:
  - `byte_ready`=1.
  - On each handshake (`byte_valid` & `byte_ready`), the byte is shifted into the assembly register at byte position 3−byte_cnt (big-endian), and byte_cnt increments.
  - On the 4th byte, goes to WRITE.
  - Cycles with `byte_valid`=0 are stalls with no state change.
- WRITE:
  - `byte_ready`=0 and `mem_we`=1 for exactly one cycle.
  - `mem_addr` = word_cnt×4, taken modulo 256.
  - `mem_wdata` = the assembled word.
  - word_cnt then increments. If it now equals the captured length, goes to DONE; otherwise goes back to LOAD.
- DONE: `done`=1 and `byte_ready`=0. A new start restarts the load from address 0.
- `start` asserted during LOAD or WRITE is ignored.
- `byte_valid` is ignored outside LOAD; bytes are never accepted there.
- Reset mid-load: outputs are cleared and no `mem_we` pulse is issued. A partially assembled word is discarded.

## Timing
- Reset values:
  - `byte_ready`=0, `mem_we`=0, `mem_addr`=8'h00, `mem_wdata`=32'h0, `busy`=0, `done`=0, `checksum`=8'h00.
  - State = IDLE.
- All outputs are registered or decoded from the registered state only, with no combinational path from inputs.
- Start accepted on edge N: `busy`=1 and `byte_ready`=1 from cycle N+1.
- 4th byte handshake on edge K: `mem_we`=1 during cycle K+1, and the write is committed by the memory on edge K+2.
- Minimum time per word is 5 cycles (4 accept + 1 write). A full 64-word load takes at least 320 cycles after start.
- `done` rises in the cycle after the final `mem_we` cycle. `busy` falls at the same time.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - `checksum` is a running XOR of every accepted byte, updated on each handshake.
  - It is cleared to 8'h00 on an accepted start and holds its value in DONE.
- `IMEM_LOADER_CHECKSUM_EN` undefined:
  - `checksum` is constant 8'h00.
  - No checksum register is synthesized.

## Test plan
- **One-word load:** reset, then start with `len_words`=1 and bytes E3,A0,10,05 on consecutive cycles → exactly one `mem_we` pulse, `mem_addr`=00, `mem_wdata`=E3A01005. Then `done`=1, `busy`=0, `byte_ready`=0.
- **Four words with stalls:** `len_words`=4, 16 bytes 00..0F with `byte_valid` randomly deasserted → writes at addresses 00/04/08/0C with data 00010203/04050607/08090A0B/0C0D0E0F. No byte is lost or duplicated.
- **Zero length and ignored start:** `len_words`=0 → `done`=1 the next cycle with no `mem_we`. A second start during LOAD is ignored; the load completes with its original length.
- **Full memory and clamp:** `len_words`=64 → the last write is at `mem_addr`=FC. `len_words`=100 → also stops after 64 writes.
- **Reset mid-load:** reset asserted after 2 of 4 bytes → outputs are at their reset values immediately and no write occurs. A new 1-word load afterwards writes correctly at address 00.
- **Checksum (macro defined):** bytes 12,34,56,78 → `checksum`=08. With the macro undefined → `checksum` stays 00.
